coeff_mem_streamer: RTL and testbench

- Read-side companion to the distributed polynomial coefficient RAMs used in the SNTRUP757 datapath.
- Those RAMs offer a synchronous write port and an asynchronous (combinational) read port.
- On a start command, this block walks a contiguous address range of one such RAM and streams the 13-bit coefficients out over a valid/ready interface.
- It includes a 2-entry output buffer, so it sustains 1 coefficient/cycle under continuous ready.

---
 rtl/coeff_mem_streamer_if.sv | 24 ++
 rtl/coeff_mem_streamer.sv | 151 +++++++++++++++
 tb/tb_coeff_mem_streamer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_mem_streamer_if.sv
// Coefficient stream bundle: valid/ready beats with a last marker.
// Master drives data/valid/last, slave returns ready.
interface coeff_mem_streamer_if #(
  parameter int W = 13
) ();
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/coeff_mem_streamer.sv
// Walks an address range of an async-read coefficient RAM and
// streams the words out through a 2-entry valid/ready buffer.
module coeff_mem_streamer #(
  parameter int RAM_WIDTH     = 13,
  parameter int RAM_ADDR_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_addr,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic [RAM_ADDR_BITS-1:0] read_address,
  input  logic [RAM_WIDTH-1:0]     output_data,
  coeff_mem_streamer_if.master     strm
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  localparam logic [RAM_ADDR_BITS-1:0] A_ONE = 1;
  localparam logic [RAM_ADDR_BITS:0]   R_ONE = 1;
  localparam logic [RAM_ADDR_BITS:0]   R_ZERO = '0;

  state_e                   state_q, state_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_ADDR_BITS:0]   rem_q, rem_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [RAM_WIDTH-1:0]     d0_q, d0_d;
  logic [RAM_WIDTH-1:0]     d1_q, d1_d;
  logic                     l0_q, l0_d;
  logic                     l1_q, l1_d;
  logic                     done_q, done_d;

  logic pop;
  logic fetch;
  logic new_last;

  assign pop      = (cnt_q != 2'd0) && strm.out_ready;
  assign fetch    = (state_q == FETCH) &&
                    ((cnt_q != 2'd2) || pop);
  assign new_last = (rem_q == R_ONE);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (length == R_ZERO) begin
            done_d = 1'b1;
          end else begin
            addr_d  = base_addr;
            rem_d   = length;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        if (fetch) begin
          addr_d = addr_q + A_ONE;
          rem_d  = rem_q - R_ONE;
          if (new_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && l0_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is always the head; entry 1 shifts down on pop.
  always_comb begin
    cnt_d = cnt_q;
    d0_d  = d0_q;
    d1_d  = d1_q;
    l0_d  = l0_q;
    l1_d  = l1_q;
    unique case (1'b1)
      fetch && !pop: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          d0_d = output_data;
          l0_d = new_last;
        end else begin
          d1_d = output_data;
          l1_d = new_last;
        end
      end
      !fetch && pop: begin
        cnt_d = cnt_q - 2'd1;
        d0_d  = d1_q;
        l0_d  = l1_q;
      end
      fetch && pop: begin
        if (cnt_q == 2'd1) begin
          d0_d = output_data;
          l0_d = new_last;
        end else begin
          d0_d = d1_q;
          l0_d = l1_q;
          d1_d = output_data;
          l1_d = new_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= 2'd0;
      d0_q    <= '0;
      d1_q    <= '0;
      l0_q    <= 1'b0;
      l1_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      l0_q    <= l0_d;
      l1_q    <= l1_d;
      done_q  <= done_d;
    end
  end

  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign read_address   = addr_q;
  assign strm.out_valid = (cnt_q != 2'd0);
  assign strm.out_data  = d0_q;
  assign strm.out_last  = l0_q;

endmodule

// File: tb/tb_coeff_mem_streamer.sv
// Scoreboard bench for coeff_mem_streamer with an async-read RAM model.
// Expected beats are queued at start and compared on each transfer.
module tb_coeff_mem_streamer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] length = '0;
  logic        busy;
  logic        done;
  logic [10:0] read_address;
  logic [12:0] output_data;

  logic [12:0] ram [2048];
  logic [13:0] sb [$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t_start = 0;

  int beats, done_cnt, done_rel, busy_cnt, valid_cnt;
  int first_rel, last_rel;

  bit          bp_en = 1'b0;
  logic [10:0] bp_base = '0;
  int          bp_i = 0;
  bit          pat [8] = '{1, 0, 0, 1, 0, 1, 1, 0};

  logic        prev_stall = 1'b0;
  logic [12:0] prev_data = '0;
  logic        prev_last = 1'b0;

  coeff_mem_streamer_if #(.W(13)) s ();

  coeff_mem_streamer #(
    .RAM_WIDTH    (13),
    .RAM_ADDR_BITS(11)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .read_address(read_address),
    .output_data (output_data),
    .strm        (s)
  );

  assign output_data = ram[read_address];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (bp_en) begin
      s.out_ready = pat[bp_i];
      bp_i = (bp_i + 1) % 8;
    end else begin
      s.out_ready = 1'b1;
      bp_i = 0;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [13:0] e;
    logic [10:0] diff;
    int          rel, occ;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      rel = cyc - t_start;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_rel = rel;
      end
      if (s.out_valid) valid_cnt++;
      if (prev_stall) begin
        check("stall_data", int'(s.out_data), int'(prev_data));
        check("stall_last", int'(s.out_last), int'(prev_last));
      end
      if (bp_en && busy) begin
        diff = read_address - bp_base;
        occ  = int'(diff) - beats;
        check("bp_valid", int'(s.out_valid), int'(occ > 0));
        check("bp_cap", int'(occ >= 0 && occ <= 2), 1);
      end
      if (s.out_valid && s.out_ready) begin
        if (sb.size() == 0) begin
          check("extra_beat", 1, 0);
        end else begin
          e = sb.pop_front();
          check("beat_data", int'(s.out_data), int'(e[12:0]));
          check("beat_last", int'(s.out_last), int'(e[13]));
        end
        if (beats == 0) first_rel = rel;
        last_rel = rel;
        beats++;
      end
      prev_stall = s.out_valid && !s.out_ready;
      prev_data  = s.out_data;
      prev_last  = s.out_last;
    end
  end

  task automatic clear_stats();
    beats     = 0;
    done_cnt  = 0;
    done_rel  = -1;
    busy_cnt  = 0;
    valid_cnt = 0;
    first_rel = -1;
    last_rel  = -1;
  endtask

  task automatic drive_start(input logic [10:0] b, input logic [11:0] n);
    start     = 1'b1;
    base_addr = b;
    length    = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic go(input logic [10:0] b, input logic [11:0] n);
    logic [10:0] a;
    @(posedge clk);
    #1;
    clear_stats();
    t_start = cyc;
    for (int i = 0; i < int'(n); i++) begin
      a = b + 11'(i);
      sb.push_back({(i == int'(n) - 1), ram[a]});
    end
    drive_start(b, n);
  endtask

  task automatic wait_done(input int lim);
    int i;
    i = 0;
    while (done_cnt == 0 && i < lim) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (done_cnt == 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 13'(i % 4591);
    clear_stats();

    #2 rst_n = 1'b0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(read_address), 0);
    check("rst_valid", int'(s.out_valid), 0);
    check("rst_last", int'(s.out_last), 0);
    check("rst_data", int'(s.out_data), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // full polynomial
    go(11'd0, 12'd757);
    wait_done(1000);
    check("full_beats", beats, 757);
    check("full_first", first_rel, 2);
    check("full_last", last_rel, 758);
    check("full_done", done_rel, 759);
    check("full_busy", busy_cnt, 758);
    check("full_sb", sb.size(), 0);

    // wrap-around
    go(11'd2040, 12'd16);
    for (int k = 0; k < 16; k++) begin
      check("wrap_addr", int'(read_address), (2040 + k) % 2048);
      @(posedge clk);
      #1;
    end
    wait_done(100);
    check("wrap_beats", beats, 16);
    check("wrap_done", done_rel, 18);
    check("wrap_sb", sb.size(), 0);

    // backpressure
    bp_base = 11'd100;
    bp_en   = 1'b1;
    go(11'd100, 12'd8);
    wait_done(200);
    bp_en = 1'b0;
    check("bp_beats", beats, 8);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_sb", sb.size(), 0);

    // zero length
    go(11'd10, 12'd0);
    wait_done(10);
    repeat (4) @(negedge clk);
    #1;
    check("zero_done_rel", done_rel, 1);
    check("zero_done_cnt", done_cnt, 1);
    check("zero_busy", busy_cnt, 0);
    check("zero_valid", valid_cnt, 0);

    // start while busy is ignored
    go(11'd300, 12'd6);
    drive_start(11'd500, 12'd3);
    wait_done(100);
    repeat (8) @(negedge clk);
    #1;
    check("sib_beats", beats, 6);
    check("sib_done_cnt", done_cnt, 1);
    check("sib_busy", int'(busy), 0);
    check("sib_sb", sb.size(), 0);

    // reset mid-operation
    go(11'd600, 12'd20);
    for (int i = 0; i < 100 && beats < 5; i++) begin
      @(negedge clk);
      #1;
    end
    check("rst_mid_reach", int'(beats >= 5), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rmid_valid", int'(s.out_valid), 0);
    check("rmid_busy", int'(busy), 0);
    check("rmid_addr", int'(read_address), 0);
    check("rmid_done", int'(done), 0);
    check("rmid_pre_done", done_cnt, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    repeat (3) @(negedge clk);
    #1;
    check("rmid_no_done", done_cnt, 0);
    check("rmid_idle_busy", busy_cnt, 0);
    check("rmid_idle_valid", valid_cnt, 0);

    go(11'd1000, 12'd4);
    wait_done(50);
    check("post_beats", beats, 4);
    check("post_done", done_rel, 6);
    check("post_sb", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
